// File: rtl/ones_count_accumulator.sv
// Frame accumulator: sums FRAME_LEN 4-bit ones counts, then flags majority and overflow.
// Define ACC_SAT_EN to clamp the sum at full scale; the default build wraps it modulo 2^ACC_W.
module ones_count_accumulator #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_major,
  output logic             out_ovf
);

  // Wide enough for both 2*sum and the 15*FRAME_LEN threshold (at most 3825).
  localparam int unsigned      MAJ_W    = (ACC_W + 1 > 12) ? ACC_W + 1 : 12;
  localparam logic [MAJ_W-1:0] MAJ_THR  = MAJ_W'(15 * FRAME_LEN);
  localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_sum, w_sum_nxt, w_base;
  logic [7:0]       r_beats, w_beats_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_major, r_out_ovf;
  logic             w_accept, w_first, w_last, w_carry;
  logic [ACC_W:0]   w_add;
  logic [MAJ_W-1:0] w_sum_x2;

  assign w_accept = in_valid && (r_state != StDone);
  assign w_first  = (r_state == StIdle);

  // The first beat of a frame starts from zero, which also drops a stale overflow flag.
  assign w_base  = w_first ? '0 : r_sum;
  assign w_add   = {1'b0, w_base} + (ACC_W + 1)'(in_cnt);
  assign w_carry = w_add[ACC_W];

`ifdef ACC_SAT_EN
  // Once clamped, every later add carries again (or adds 0), so the sum stays at full scale.
  assign w_sum_nxt = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
  assign w_sum_nxt = w_add[ACC_W-1:0];
`endif

  assign w_ovf_nxt   = w_carry | (~w_first & r_ovf);
  assign w_beats_nxt = w_first ? 8'd1 : r_beats + 8'd1;
  assign w_last      = w_first ? (FRAME_LEN == 1) : (r_beats == LAST_IDX);
  assign w_sum_x2    = MAJ_W'(w_sum_nxt) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    unique case (r_state)
      StIdle, StAccum: begin
        if (w_accept) begin
          w_state_nxt = w_last ? StDone : StAccum;
        end
      end
      StDone: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_beats     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_major <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum   <= w_sum_nxt;
        r_beats <= w_beats_nxt;
        r_ovf   <= w_ovf_nxt;
      end
      // Result registers are loaded with the last beat folded in and zeroed when DONE is left.
      if (w_accept && w_last) begin
        r_out_sum   <= w_sum_nxt;
        r_out_major <= (w_sum_x2 > MAJ_THR);
        r_out_ovf   <= w_ovf_nxt;
      end else if ((r_state == StDone) && out_ready) begin
        r_out_sum   <= '0;
        r_out_major <= 1'b0;
        r_out_ovf   <= 1'b0;
      end
    end
  end

  assign out_sum   = r_out_sum;
  assign out_major = r_out_major;
  assign out_ovf   = r_out_ovf;

endmodule

// File: doc/ones_count_accumulator.md
ONES_COUNT_ACCUMULATOR -- requirements
Module: ones_count_accumulator

Interface
REQ-001 Parameter FRAME_LEN, default 16, number of count beats per frame; legal 1..255.
REQ-002 Parameter ACC_W, default 8, width of the frame sum.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_cnt carries a valid beat.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_cnt  input  4  one 15-input ones count, range 0..15.
REQ-008 out_valid  output  1  frame result available.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 out_sum  output  ACC_W  sum of the FRAME_LEN accepted beats.
REQ-011 out_major  output  1  frame majority: 2*out_sum > 15*FRAME_LEN.
REQ-012 out_ovf  output  1  true sum exceeded 2^ACC_W-1 during the frame.

Function
REQ-013 The block SHALL implement states IDLE, ACCUM, DONE.
REQ-014 A beat SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE.
REQ-015 Cycles with in_valid=0 SHALL leave the sum, beat counter and state unchanged.
REQ-016 IDLE: accepted beat loads sum=in_cnt, beat count=1, goes to ACCUM (or DONE if FRAME_LEN=1).
REQ-017 ACCUM: accepted beat adds in_cnt to sum and increments beat count; the FRAME_LEN-th beat moves to DONE.
REQ-018 out_valid SHALL be 1 exactly in DONE, asserted the cycle after the last beat is accepted (latency 1).
REQ-019 out_sum, out_major, out_ovf SHALL be registered, stable for the whole of DONE, and include the last beat.
REQ-020 out_major SHALL be evaluated on the registered out_sum value; equality (2*sum = 15*FRAME_LEN) gives 0.
REQ-021 out_ovf SHALL be sticky within a frame and cleared at the first beat of the next frame.
REQ-022 DONE with out_ready=1 SHALL return to IDLE next cycle; out_ready=0 SHALL hold DONE indefinitely.
REQ-023 in_valid asserted during DONE SHALL be ignored and no beat counted.
REQ-024 out_sum, out_major, out_ovf SHALL read 0 outside DONE.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sum=0, beat count=0, out_valid=0, out_sum=0, out_major=0, out_ovf=0, in_ready=1.
REQ-026 Reset asserted mid-frame or in DONE SHALL discard the partial frame/result; the next frame SHALL start from sum 0.
REQ-027 After rst_n deasserts, the first accepted beat SHALL be treated as the first beat of a frame.

Configuration
REQ-028 Macro ACC_SAT_EN defined: a sum exceeding 2^ACC_W-1 SHALL clamp at 2^ACC_W-1 for the rest of the frame and set out_ovf.
REQ-029 Macro ACC_SAT_EN undefined: the sum SHALL wrap modulo 2^ACC_W and out_ovf SHALL be set on any carry out of bit ACC_W-1.

Verification
REQ-030 Reset: hold rst_n=0 for 3 cycles mid-stream -> out_valid=0, out_sum=0, in_ready=1; then 16 beats of 1 -> out_sum=16, not carrying pre-reset beats.
REQ-031 Full frame: 16 back-to-back beats of 15 -> one cycle later out_valid=1, out_sum=240, out_major=1, out_ovf=0.
REQ-032 Majority boundary: 8 beats of 15 + 8 beats of 0 -> out_sum=120, out_major=0; repeat with one 0 replaced by 1 -> out_sum=121, out_major=1.
REQ-033 Gaps and backpressure: 16 beats of 3 with in_valid toggling, then out_ready=0 for 5 cycles with in_valid=1 -> out_sum=48 held, in_ready=0, no beat absorbed; out_ready=1 -> IDLE next cycle.
REQ-034 Overflow, ACC_W=7: 16 beats of 15 -> with ACC_SAT_EN out_sum=127, out_ovf=1; without it out_sum=112, out_ovf=1.
REQ-035 FRAME_LEN=1: single beat of 9 -> out_valid next cycle, out_sum=9, out_major=1.
